// File: rtl/multicycle_control.sv
// Multi-cycle sequencer (FETCH/DECODE/EXEC/WB) for the 4-bit-opcode ALU datapath; optional RETIRE_CNT_EN adds a retire counter.
// Latency: 4 cycles per instruction with immediate imem_ready, plus one cycle per memory wait; outputs registered except pc/ir strobes.
// Backpressure: FETCH holds imem_req until imem_ready; the watchdog halts after FETCH_TIMEOUT waits (0 disables it).
module multicycle_control #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int TO_W          = 5,
    parameter int RCNT_W        = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic [3:0]        op_i,
    input  logic              imem_ready_i,
    output logic              imem_req_o,
    output logic              pc_write_o,
    output logic              ir_write_o,
    output logic              reg_dst_o,
    output logic              alu_src_o,
    output logic              reg_write_o,
    output logic [2:0]        alu_ctl_o,
    output logic              illegal_op_o,
    output logic              halted_o,
    output logic              fetch_err_o,
    output logic              busy_o,
    output logic [RCNT_W-1:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    // {reg_dst, alu_src, alu_ctl[2:0]}
    function automatic logic [4:0] ctl_of(input logic [3:0] op);
        case (op)
            4'b0000: return 5'b1_0_010;
            4'b0001: return 5'b1_0_110;
            4'b0010: return 5'b1_0_000;
            4'b0011: return 5'b1_0_001;
            4'b0100: return 5'b0_1_010;
            4'b0111: return 5'b1_0_111;
            default: return 5'b0_0_000;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              fetch_err_q, fetch_err_d;
    logic              illegal_q, illegal_d;
    logic              imem_req_q, reg_write_q, halted_q, busy_q;
    logic [4:0]        ctl_q, ctl_d;
    logic [4:0]        ctl_new, ctl_held;

    assign ctl_new  = ctl_of(op_i);
    assign ctl_held = ctl_of(op_q);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        fetch_err_d = fetch_err_q;
        illegal_d   = 1'b0;
        case (state_q)
            S_IDLE: if (run_i) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready_i) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (FETCH_TIMEOUT != 0 && wait_d == TO_W'(FETCH_TIMEOUT)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                op_d = op_i;
                if (is_alu_op(op_i)) begin
                    state_d = S_EXEC;
                end else if (op_i == 4'b1111) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = run_i ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = run_i ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Control vector is decoded one cycle ahead so it is a clean register output.
        ctl_d = 5'b0;
        if (state_d == S_EXEC)    ctl_d = ctl_new;
        else if (state_d == S_WB) ctl_d = ctl_held;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= 4'b0;
            wait_q      <= '0;
            fetch_err_q <= 1'b0;
            illegal_q   <= 1'b0;
            imem_req_q  <= 1'b0;
            reg_write_q <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
            ctl_q       <= 5'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
            illegal_q   <= illegal_d;
            imem_req_q  <= (state_d == S_FETCH);
            reg_write_q <= (state_d == S_WB);
            halted_q    <= (state_d == S_HALT);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
            ctl_q       <= ctl_d;
        end
    end

    // Strobes must see imem_ready in the same cycle, so they are the only Mealy outputs.
    assign pc_write_o   = (state_q == S_FETCH) && imem_ready_i;
    assign ir_write_o   = (state_q == S_FETCH) && imem_ready_i;
    assign imem_req_o   = imem_req_q;
    assign reg_dst_o    = ctl_q[4];
    assign alu_src_o    = ctl_q[3];
    assign alu_ctl_o    = ctl_q[2:0];
    assign reg_write_o  = reg_write_q;
    assign illegal_op_o = illegal_q;
    assign halted_o     = halted_q;
    assign fetch_err_o  = fetch_err_q;
    assign busy_o       = busy_q;

`ifdef RETIRE_CNT_EN
    logic [RCNT_W-1:0] retire_q;

    always_ff @(posedge clock_i) begin
        if (reset_i)               retire_q <= '0;
        else if (state_q == S_WB)  retire_q <= retire_q + 1'b1;
    end

    assign retire_cnt_o = retire_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level planner emits per-cycle stimulus and expected outputs.
module tb_multicycle_control;

    localparam int TMO = 16;

    typedef struct packed {
        logic        imem_req;
        logic        pc_write;
        logic        ir_write;
        logic        reg_dst;
        logic        alu_src;
        logic        reg_write;
        logic [2:0]  alu_ctl;
        logic        illegal_op;
        logic        halted;
        logic        fetch_err;
        logic        busy;
        logic [15:0] retire;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  op;
    logic        rdy;
    logic        imem_req, pc_write, ir_write, reg_dst, alu_src, reg_write;
    logic [2:0]  alu_ctl;
    logic        illegal_op, halted, fetch_err, busy;
    logic [15:0] retire_cnt;

    always #5 clk = ~clk;

    multicycle_control #(.FETCH_TIMEOUT(TMO), .TO_W(5), .RCNT_W(16)) dut (
        .clock_i(clk), .reset_i(rst), .run_i(run), .op_i(op), .imem_ready_i(rdy),
        .imem_req_o(imem_req), .pc_write_o(pc_write), .ir_write_o(ir_write),
        .reg_dst_o(reg_dst), .alu_src_o(alu_src), .reg_write_o(reg_write),
        .alu_ctl_o(alu_ctl), .illegal_op_o(illegal_op), .halted_o(halted),
        .fetch_err_o(fetch_err), .busy_o(busy), .retire_cnt_o(retire_cnt)
    );

    bit         q_rst[$];
    bit         q_run[$];
    bit         q_rdy[$];
    logic [3:0] q_op[$];
    vec_t       q_exp[$];
    vec_t       act[$];

    int m_retire;
    bit m_pend;
    bit m_err;
    int total;
    int bad;
    int t_to;
    int t_h;

    logic [3:0] legal_ops[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    logic [4:0] legal_ctl[6] = '{5'b10010, 5'b10110, 5'b10000, 5'b10001, 5'b01010, 5'b10111};

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic emit(input bit r, input bit rn, input bit rd, input logic [3:0] o, input vec_t e);
        e.illegal_op = m_pend;
        m_pend       = 1'b0;
        e.fetch_err  = m_err;
`ifdef RETIRE_CNT_EN
        e.retire = 16'(m_retire);
`else
        e.retire = '0;
`endif
        q_rst.push_back(r);
        q_run.push_back(rn);
        q_rdy.push_back(rd);
        q_op.push_back(o);
        q_exp.push_back(e);
    endtask

    task automatic model_reset();
        m_retire = 0;
        m_err    = 1'b0;
        m_pend   = 1'b0;
    endtask

    task automatic idle_go(input int n);
        vec_t e = '0;
        for (int k = 0; k < n; k++) emit(1'b0, 1'b0, rb(), rop(), e);
        emit(1'b0, 1'b1, rb(), rop(), e);
    endtask

    task automatic halt_cycles(input int n, input bit force_run);
        vec_t e = '0;
        e.halted = 1'b1;
        for (int k = 0; k < n; k++) emit(1'b0, force_run ? 1'b1 : rb(), rb(), rop(), e);
    endtask

    task automatic reset_from_halt();
        vec_t e = '0;
        e.halted = 1'b1;
        emit(1'b1, rb(), rb(), rop(), e);
        model_reset();
    endtask

    // Fetch with `waits` non-ready cycles; the watchdog fires once TMO waits accumulate.
    task automatic do_fetch(input int waits, output bit to);
        vec_t e = '0;
        e.imem_req = 1'b1;
        e.busy     = 1'b1;
        to = 1'b0;
        if (waits >= TMO) begin
            for (int k = 0; k < TMO; k++) emit(1'b0, rb(), 1'b0, rop(), e);
            m_err = 1'b1;
            to    = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) emit(1'b0, rb(), 1'b0, rop(), e);
            e.pc_write = 1'b1;
            e.ir_write = 1'b1;
            emit(1'b0, rb(), 1'b1, rop(), e);
        end
    endtask

    // nxt: 0 = back to idle, 1 = straight into fetch, 2 = halted
    task automatic do_instr(input int waits, input logic [3:0] o, input bit run_wb,
                            input bit rst_exec, output int nxt);
        bit         to;
        bit         legal = 1'b0;
        logic [4:0] c = '0;
        vec_t       e = '0;
        do_fetch(waits, to);
        if (to) begin
            nxt = 2;
            return;
        end
        for (int k = 0; k < 6; k++) begin
            if (legal_ops[k] == o) begin
                legal = 1'b1;
                c     = legal_ctl[k];
            end
        end
        e.busy = 1'b1;
        if (legal) begin
            emit(1'b0, rb(), rb(), o, e);
            e.reg_dst = c[4];
            e.alu_src = c[3];
            e.alu_ctl = c[2:0];
            emit(rst_exec, rb(), rb(), rop(), e);
            if (rst_exec) begin
                model_reset();
                nxt = 0;
                return;
            end
            e.reg_write = 1'b1;
            emit(1'b0, run_wb, rb(), rop(), e);
            m_retire++;
            nxt = run_wb ? 1 : 0;
        end else if (o == 4'hF) begin
            emit(1'b0, rb(), rb(), o, e);
            nxt = 2;
        end else begin
            emit(1'b0, run_wb, rb(), o, e);
            m_pend = 1'b1;
            nxt    = run_wb ? 1 : 0;
        end
    endtask

    task automatic build_trace();
        int         nxt;
        logic [3:0] seq[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
        logic [3:0] o;
        int         k;
        idle_go(0);
        do_instr(0, 4'd0, 1'b1, 1'b0, nxt);
        do_instr(0, 4'd0, 1'b1, 1'b0, nxt);
        foreach (seq[i]) do_instr(0, seq[i], 1'b1, 1'b0, nxt);
        do_instr(0, 4'd5, 1'b1, 1'b0, nxt);
        do_instr(TMO - 1, 4'd3, 1'b0, 1'b0, nxt);
        idle_go(2);
        do_instr(1, 4'd4, 1'b1, 1'b1, nxt);
        idle_go(1);
        do_instr(2, 4'd1, 1'b0, 1'b0, nxt);
        idle_go(0);
        do_instr(0, 4'd6, 1'b0, 1'b0, nxt);
        for (int n = 0; n < 60; n++) begin
            if (nxt == 0) idle_go($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) begin
                o = legal_ops[$urandom_range(0, 5)];
            end else begin
                k = $urandom_range(0, 8);
                o = (k < 2) ? 4'(5 + k) : 4'(6 + k);
            end
            do_instr($urandom_range(0, 5), o, ($urandom_range(0, 3) != 0), 1'b0, nxt);
        end
        if (nxt == 0) idle_go(0);
        t_to = q_exp.size();
        do_instr(TMO, 4'd0, 1'b1, 1'b0, nxt);
        halt_cycles(20, 1'b0);
        reset_from_halt();
        idle_go(0);
        do_instr(0, 4'hF, 1'b1, 1'b0, nxt);
        t_h = q_exp.size();
        halt_cycles(20, 1'b1);
        reset_from_halt();
        idle_go(2);
    endtask

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        vec_t cur;
        total = 0;
        bad   = 0;
        model_reset();
        build_trace();
        rst = 1'b1; run = 1'b0; op = 4'd0; rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < q_exp.size(); i++) begin
            #1;
            rst = q_rst[i]; run = q_run[i]; rdy = q_rdy[i]; op = q_op[i];
            @(negedge clk);
            cur = '{imem_req, pc_write, ir_write, reg_dst, alu_src, reg_write, alu_ctl,
                    illegal_op, halted, fetch_err, busy, retire_cnt};
            act.push_back(cur);
            total++;
            if (cur !== q_exp[i]) begin
                bad++;
                $display("FAIL trace cyc=%0d got=%h want=%h", i, cur, q_exp[i]);
            end
            @(posedge clk);
        end

        lit("reset_idle", {14'd0, act[0].imem_req, act[0].busy}, 16'd0);
        lit("first_fetch", {13'd0, act[1].imem_req, act[1].pc_write, act[1].ir_write}, 16'h7);
        lit("exec_no_wr", {15'd0, act[3].reg_write}, 16'd0);
        lit("wb_add", {10'd0, act[4].reg_dst, act[4].alu_src, act[4].reg_write, act[4].alu_ctl}, 16'h2A);
        lit("wb_add2", {10'd0, act[8].reg_dst, act[8].alu_src, act[8].reg_write, act[8].alu_ctl}, 16'h2A);
        lit("wb_sub", {10'd0, act[12].reg_dst, act[12].alu_src, act[12].reg_write, act[12].alu_ctl}, 16'h2E);
        lit("wb_addi", {10'd0, act[24].reg_dst, act[24].alu_src, act[24].reg_write, act[24].alu_ctl}, 16'h1A);
        lit("wb_slt", {10'd0, act[28].reg_dst, act[28].alu_src, act[28].reg_write, act[28].alu_ctl}, 16'h2F);
`ifdef RETIRE_CNT_EN
        lit("retire_7", act[29].retire, 16'd7);
`else
        lit("retire_tied", act[29].retire, 16'd0);
`endif
        lit("illegal_pulse", {15'd0, act[31].illegal_op}, 16'd1);
        lit("illegal_once", {15'd0, act[32].illegal_op}, 16'd0);
        lit("ready_wins", {14'd0, act[46].pc_write, act[47].halted}, 16'h2);
        lit("idle_not_busy", {15'd0, act[50].busy}, 16'd0);
        lit("pre_timeout", {14'd0, act[t_to + 15].imem_req, act[t_to + 15].halted}, 16'h2);
        lit("timeout_halt", {14'd0, act[t_to + 16].halted, act[t_to + 16].fetch_err}, 16'h3);
        lit("halt_op_hold", {14'd0, act[t_h + 19].imem_req, act[t_h + 19].halted}, 16'h1);
        lit("end_idle", {13'd0, act[act.size() - 1].halted, act[act.size() - 1].fetch_err,
                         act[act.size() - 1].busy}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
